bean_tracker: RTL and testbench

Maze bean map and eat detector that produces the `power` level consumed by the power-bean counter. It holds a bitmap of remaining regular beans and power beans, checks Pac-Man's tile on every move tick, clears eaten beans, updates score and remaining-bean count, and flags level clear. It sits between the Pac-Man movement logic (tile coordinates, move strobe) and the power-effect counter and VGA renderer (bean read port).

---
 rtl/bean_tracker.sv | 140 ++++++++++++++
 tb/tb_bean_tracker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bean_tracker.sv
// Bean/power-bean bitmap with eat detection on move ticks, score, bean count and level-clear flag.
// A tile present in both maps is eaten as a power bean and counted once.
module bean_tracker #(
    parameter int COLS = 16,
    parameter int ROWS = 12,
    parameter logic [COLS*ROWS-1:0] BEAN_MAP = '1,
    parameter logic [COLS*ROWS-1:0] POWER_MAP =
        ({{(COLS*ROWS-1){1'b0}}, 1'b1}) |
        ({{(COLS*ROWS-1){1'b0}}, 1'b1} << (COLS-1)) |
        ({{(COLS*ROWS-1){1'b0}}, 1'b1} << ((ROWS-1)*COLS)) |
        ({{(COLS*ROWS-1){1'b0}}, 1'b1} << (COLS*ROWS-1))
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  scene_i,
    input  logic        move_tick_i,
    input  logic [3:0]  pac_x_i,
    input  logic [3:0]  pac_y_i,
    input  logic [3:0]  rd_x_i,
    input  logic [3:0]  rd_y_i,
    output logic        rd_bean_o,
    output logic        rd_power_o,
    output logic        power_o,
    output logic [11:0] score_o,
    output logic [7:0]  beans_left_o,
    output logic        all_clear_o
);

    localparam int N = COLS * ROWS;

    function automatic int popcount(input logic [N-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < N; k++) n += int'(v[k]);
        return n;
    endfunction

    localparam int          INIT_COUNT = popcount(BEAN_MAP | POWER_MAP);
    localparam logic [7:0]  INIT_LEFT  = 8'(INIT_COUNT);
    localparam logic [4:0]  COLS_W     = 5'(COLS);
    localparam logic [4:0]  ROWS_W     = 5'(ROWS);
    localparam logic [7:0]  COLS_8     = 8'(COLS);

    typedef enum logic [1:0] {LOAD, PLAY, DONE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] bean_q, bean_d;
    logic [N-1:0] pwr_q, pwr_d;
    logic         power_q, power_d;
    logic [11:0]  score_q, score_d;
    logic [7:0]   left_q, left_d;
    logic         rd_bean_q, rd_bean_d;
    logic         rd_power_q, rd_power_d;

    logic         pac_in, rd_in;
    logic [7:0]   pac_idx, rd_idx;
    logic [3:0]   score_add;
    logic [12:0]  score_sum;

    assign pac_in  = ({1'b0, pac_x_i} < COLS_W) && ({1'b0, pac_y_i} < ROWS_W);
    assign rd_in   = ({1'b0, rd_x_i} < COLS_W) && ({1'b0, rd_y_i} < ROWS_W);
    assign pac_idx = {4'b0, pac_y_i} * COLS_8 + {4'b0, pac_x_i};
    assign rd_idx  = {4'b0, rd_y_i} * COLS_8 + {4'b0, rd_x_i};

    assign score_add = (pac_in && pwr_q[pac_idx]) ? 4'd5 : 4'd1;
    assign score_sum = {1'b0, score_q} + {9'b0, score_add};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LOAD;
            bean_q     <= BEAN_MAP;
            pwr_q      <= POWER_MAP;
            power_q    <= 1'b0;
            score_q    <= 12'd0;
            left_q     <= INIT_LEFT;
            rd_bean_q  <= 1'b0;
            rd_power_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bean_q     <= bean_d;
            pwr_q      <= pwr_d;
            power_q    <= power_d;
            score_q    <= score_d;
            left_q     <= left_d;
            rd_bean_q  <= rd_bean_d;
            rd_power_q <= rd_power_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bean_d     = bean_q;
        pwr_d      = pwr_q;
        power_d    = power_q;
        score_d    = score_q;
        left_d     = left_q;
        rd_bean_d  = rd_in && bean_q[rd_idx];
        rd_power_d = rd_in && pwr_q[rd_idx];

        if (scene_i == 2'b00) begin
            state_d = LOAD;
            bean_d  = BEAN_MAP;
            pwr_d   = POWER_MAP;
            power_d = 1'b0;
            score_d = 12'd0;
            left_d  = INIT_LEFT;
        end else begin
            unique case (state_q)
                LOAD: state_d = PLAY;
                PLAY: begin
                    if (left_q == 8'd0) begin
                        state_d = DONE;
                        power_d = 1'b0;
                    end else if (scene_i != 2'b01) begin
                        power_d = 1'b0;
                    end else if (move_tick_i) begin
                        power_d = 1'b0;
                        if (pac_in && (bean_q[pac_idx] || pwr_q[pac_idx])) begin
                            power_d          = pwr_q[pac_idx];
                            bean_d[pac_idx]  = 1'b0;
                            pwr_d[pac_idx]   = 1'b0;
                            left_d           = left_q - 8'd1;
                            score_d          = score_sum[12] ? 12'hFFF : score_sum[11:0];
                        end
                    end
                end
                DONE: power_d = 1'b0;
                default: state_d = LOAD;
            endcase
        end
    end

    assign rd_bean_o    = rd_bean_q;
    assign rd_power_o   = rd_power_q;
    assign power_o      = power_q;
    assign score_o      = score_q;
    assign beans_left_o = left_q;
    assign all_clear_o  = (state_q == DONE);

endmodule

// File: tb/tb_bean_tracker.sv
// Self-checking bench for bean_tracker (15x12 maze) against a behavioural tile model.
module tb_bean_tracker;

    localparam int COLS = 15;
    localparam int ROWS = 12;
    localparam int N    = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  scene;
    logic        move_tick;
    logic [3:0]  pac_x, pac_y, rd_x, rd_y;
    logic        rd_bean, rd_power, power, all_clear;
    logic [11:0] score;
    logic [7:0]  beans_left;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    bean_tracker #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk_i(clk), .rst_i(rst), .scene_i(scene), .move_tick_i(move_tick),
        .pac_x_i(pac_x), .pac_y_i(pac_y), .rd_x_i(rd_x), .rd_y_i(rd_y),
        .rd_bean_o(rd_bean), .rd_power_o(rd_power), .power_o(power),
        .score_o(score), .beans_left_o(beans_left), .all_clear_o(all_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] corners();
        logic [N-1:0] v;
        v = '0;
        v[0] = 1'b1; v[COLS-1] = 1'b1; v[(ROWS-1)*COLS] = 1'b1; v[N-1] = 1'b1;
        return v;
    endfunction

    function automatic bit is_corner(input int x, input int y);
        return (x == 0 || x == COLS-1) && (y == 0 || y == ROWS-1);
    endfunction

    // Behavioural model: tiles hold a bean or not; eating clears the tile and scores.
    logic [N-1:0] m_bean, m_pwr;
    int           m_state;   // 0 load, 1 play, 2 done
    int           m_score, m_left;
    bit           m_power, m_rdb, m_rdp;

    always @(posedge clk or posedge rst) begin
        int idx;
        if (rst) begin
            m_state <= 0;
            m_bean  <= '1;
            m_pwr   <= corners();
            m_power <= 1'b0;
            m_score <= 0;
            m_left  <= $countones({N{1'b1}} | corners());
            m_rdb   <= 1'b0;
            m_rdp   <= 1'b0;
        end else begin
            if (int'(rd_x) < COLS && int'(rd_y) < ROWS) begin
                m_rdb <= m_bean[int'(rd_y)*COLS + int'(rd_x)];
                m_rdp <= m_pwr[int'(rd_y)*COLS + int'(rd_x)];
            end else begin
                m_rdb <= 1'b0;
                m_rdp <= 1'b0;
            end
            if (scene == 2'b00) begin
                m_state <= 0;
                m_bean  <= '1;
                m_pwr   <= corners();
                m_power <= 1'b0;
                m_score <= 0;
                m_left  <= $countones({N{1'b1}} | corners());
            end else if (m_state == 0) begin
                m_state <= 1;
            end else if (m_state == 1) begin
                if (m_left == 0) begin
                    m_state <= 2;
                    m_power <= 1'b0;
                end else if (scene != 2'b01) begin
                    m_power <= 1'b0;
                end else if (move_tick) begin
                    m_power <= 1'b0;
                    if (int'(pac_x) < COLS && int'(pac_y) < ROWS) begin
                        idx = int'(pac_y)*COLS + int'(pac_x);
                        if (m_pwr[idx] || m_bean[idx]) begin
                            m_power     <= m_pwr[idx];
                            m_score     <= (m_score + (m_pwr[idx] ? 5 : 1) > 4095) ? 4095
                                           : m_score + (m_pwr[idx] ? 5 : 1);
                            m_left      <= m_left - 1;
                            m_bean[idx] <= 1'b0;
                            m_pwr[idx]  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_bean",    int'(rd_bean),    int'(m_rdb));
            chk("rd_power",   int'(rd_power),   int'(m_rdp));
            chk("power",      int'(power),      int'(m_power));
            chk("score",      int'(score),      m_score);
            chk("beans_left", int'(beans_left), m_left);
            chk("all_clear",  int'(all_clear),  (m_state == 2) ? 1 : 0);
        end
    end

    task automatic cyc(input logic [1:0] sc, input logic tk, input logic [3:0] px, input logic [3:0] py);
        scene = sc; move_tick = tk; pac_x = px; pac_y = py;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; scene = 2'b00; move_tick = 1'b0;
        pac_x = 4'd0; pac_y = 4'd0; rd_x = 4'd0; rd_y = 4'd0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        chk("reset_left", int'(beans_left), 180);
        chk("reset_score", int'(score), 0);
        chk("reset_clear", int'(all_clear), 0);
        chk("reset_rd", int'(rd_bean), 0);

        cyc(2'b01, 1'b0, 4'd0, 4'd0);
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                rd_x = 4'(x); rd_y = 4'(y);
                cyc(2'b01, 1'b0, 4'd0, 4'd0);
                chk("init_rd_bean", int'(rd_bean), 1);
                chk("init_rd_power", int'(rd_power), is_corner(x, y) ? 1 : 0);
            end
        end

        cyc(2'b01, 1'b1, 4'd2, 4'd0);
        chk("eat_reg_score", int'(score), 1);
        chk("eat_reg_left", int'(beans_left), 179);
        chk("eat_reg_power", int'(power), 0);
        cyc(2'b01, 1'b1, 4'd2, 4'd0);
        chk("re_eat_score", int'(score), 1);
        chk("re_eat_left", int'(beans_left), 179);
        cyc(2'b01, 1'b1, 4'd0, 4'd0);
        chk("eat_pwr_power", int'(power), 1);
        chk("eat_pwr_score", int'(score), 6);
        chk("eat_pwr_left", int'(beans_left), 178);
        cyc(2'b01, 1'b0, 4'd0, 4'd0);
        cyc(2'b01, 1'b0, 4'd0, 4'd0);
        chk("power_held", int'(power), 1);
        cyc(2'b01, 1'b1, 4'd2, 4'd0);
        chk("power_drop", int'(power), 0);

        cyc(2'b01, 1'b1, 4'd15, 4'd3);
        cyc(2'b01, 1'b1, 4'd3, 4'd12);
        chk("oor_score", int'(score), 6);
        chk("oor_left", int'(beans_left), 178);

        rd_x = 4'd5; rd_y = 4'd5;
        cyc(2'b10, 1'b1, 4'd5, 4'd5);
        cyc(2'b11, 1'b1, 4'd5, 4'd5);
        cyc(2'b10, 1'b1, 4'd5, 4'd5);
        chk("frozen_score", int'(score), 6);
        chk("frozen_left", int'(beans_left), 178);
        chk("frozen_rd", int'(rd_bean), 1);

        cyc(2'b00, 1'b1, 4'd5, 4'd5);
        chk("reload_score", int'(score), 0);
        chk("reload_left", int'(beans_left), 180);
        cyc(2'b01, 1'b0, 4'd0, 4'd0);

        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                cyc(2'b01, 1'b1, 4'(x), 4'(y));
        chk("all_eaten_left", int'(beans_left), 0);
        chk("all_eaten_score", int'(score), 196);
        chk("clear_not_yet", int'(all_clear), 0);
        cyc(2'b01, 1'b0, 4'd0, 4'd0);
        chk("clear_set", int'(all_clear), 1);
        chk("done_power", int'(power), 0);
        cyc(2'b01, 1'b1, 4'd3, 4'd3);
        chk("done_score", int'(score), 196);

        cyc(2'b00, 1'b0, 4'd0, 4'd0);
        cyc(2'b01, 1'b0, 4'd0, 4'd0);
        cyc(2'b01, 1'b1, 4'd4, 4'd4);
        cyc(2'b01, 1'b1, 4'd14, 4'd0);
        move_tick = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_score", int'(score), 0);
        chk("async_left", int'(beans_left), 180);
        chk("async_power", int'(power), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rd_x = 4'($urandom_range(0, 15));
            rd_y = 4'($urandom_range(0, 15));
            cyc((r < 2) ? 2'b00 : (r < 90) ? 2'b01 : 2'($urandom_range(2, 3)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
